// File: rtl/main_mem_arbiter.sv
// rtl/main_mem_arbiter.sv - two-port round-robin arbiter serialising 8/16/32-bit accesses onto a byte RAM
// Big-endian byte order; one RAM byte per cycle; registered-read RAM (data one cycle after address).
module main_mem_arbiter #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic [31:0]           r0_addr,
    input  logic [1:0]            r0_size,
    input  logic                  r0_we,
    input  logic [31:0]           r0_wdata,
    output logic                  r0_ack,
    input  logic                  r1_req,
    input  logic [31:0]           r1_addr,
    input  logic [1:0]            r1_size,
    input  logic                  r1_we,
    input  logic [31:0]           r1_wdata,
    output logic                  r1_ack,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  grant_id,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              lastk_q, lastk_d;
    logic [1:0]              k_q, k_d;
    logic                    we_q, we_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [23:0]             acc_q, acc_d;
    logic                    sel;
    logic [1:0]              sel_size;
    logic [1:0]              byte_idx;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{r0_addr[31:ADDR_WIDTH], r1_addr[31:ADDR_WIDTH]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            lastk_q <= 2'd0;
            k_q     <= 2'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            acc_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            lastk_q <= lastk_d;
            k_q     <= k_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        lastk_d  = lastk_q;
        k_d      = k_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        acc_d    = acc_q;
        sel      = (r0_req && r1_req) ? ~last_q : r1_req;
        sel_size = sel ? r1_size : r0_size;
        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    owner_d = sel;
                    last_d  = sel;
                    addr_d  = sel ? r1_addr[ADDR_WIDTH-1:0] : r0_addr[ADDR_WIDTH-1:0];
                    we_d    = sel ? r1_we : r0_we;
                    wdata_d = sel ? r1_wdata : r0_wdata;
                    lastk_d = sel_size[1] ? 2'd3 : {1'b0, sel_size[0]};
                    k_d     = 2'd0;
                    acc_d   = 24'd0;
                    state_d = XFER;
                end
            end
            XFER: begin
                k_d = k_q + 2'd1;
                // RAM returns the previous cycle's byte, so capture lags the address by one
                if (!we_q && k_q != 2'd0) begin
                    acc_d = {acc_q[15:0], mem_rdata};
                end
                if (k_q == lastk_q) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign byte_idx = lastk_q - k_q;

    always_comb begin
        busy      = (state_q != IDLE);
        grant_id  = busy & owner_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        r0_ack    = (state_q == ACK) && !owner_q;
        r1_ack    = (state_q == ACK) && owner_q;
        rdata     = 32'd0;
        if (state_q == XFER) begin
            mem_addr = addr_q + ADDR_WIDTH'(k_q);
            mem_we   = we_q;
            if (we_q) begin
                case (byte_idx)
                    2'd0:    mem_wdata = wdata_q[7:0];
                    2'd1:    mem_wdata = wdata_q[15:8];
                    2'd2:    mem_wdata = wdata_q[23:16];
                    default: mem_wdata = wdata_q[31:24];
                endcase
            end
        end
        // Final byte is still on mem_rdata during ACK; the cleared accumulator zero-extends short reads
        if (state_q == ACK && !we_q) begin
            rdata = {acc_q, mem_rdata};
        end
    end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb/tb_main_mem_arbiter.sv - randomized self-checking bench for main_mem_arbiter against a transaction-level model
module tb_main_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r1_req;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic [1:0]  r0_size, r1_size;
    logic        r0_we, r1_we;
    logic        r0_ack, r1_ack;
    logic [31:0] rdata;
    logic        busy, grant_id;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          last_g   = 1;

    always #5 clk = ~clk;

    main_mem_arbiter #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_size(r0_size), .r0_we(r0_we),
        .r0_wdata(r0_wdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_size(r1_size), .r1_we(r1_we),
        .r1_wdata(r1_wdata), .r1_ack(r1_ack),
        .rdata(rdata), .busy(busy), .grant_id(grant_id),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    // Applies one access to the reference RAM and returns the value the port should see
    function automatic logic [31:0] model_access(input logic [31:0] addr, input logic [1:0] size,
                                                 input logic we, input logic [31:0] wd);
        logic [31:0] v = 32'd0;
        logic [15:0] a;
        int n = nbytes(size);
        for (int k = 0; k < n; k++) begin
            a = addr[15:0] + 16'(k);
            if (we) ref_mem[a] = 8'(wd >> (8 * (n - 1 - k)));
            else    v = (v << 8) | {24'd0, ref_mem[a]};
        end
        return v;
    endfunction

    task automatic run_req(input bit e0, input bit e1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [1:0] s0, input logic [1:0] s1,
                           input logic w0, input logic w1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input bit scramble);
        int          first, second;
        int          exp_cyc[2];
        logic [31:0] exp_val[2];
        bit          done[2];
        first  = (e0 && e1) ? 1 - last_g : (e1 ? 1 : 0);
        second = 1 - first;
        done   = '{!e0, !e1};
        exp_val[first] = (first == 0) ? model_access(a0, s0, w0, d0) : model_access(a1, s1, w1, d1);
        exp_cyc[first] = nbytes(first == 0 ? s0 : s1) + 1;
        last_g = first;
        if (e0 && e1) begin
            exp_val[second] = (second == 0) ? model_access(a0, s0, w0, d0) : model_access(a1, s1, w1, d1);
            exp_cyc[second] = exp_cyc[first] + 1 + nbytes(second == 0 ? s0 : s1) + 1;
            last_g = second;
        end
        @(negedge clk);
        r0_req = e0; r0_addr = a0; r0_size = s0; r0_we = w0; r0_wdata = d0;
        r1_req = e1; r1_addr = a1; r1_size = s1; r1_we = w1; r1_wdata = d1;
        for (int cyc = 1; cyc <= 30 && !(done[0] && done[1]); cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check_eq("busy_after_grant", busy, 1);
                check_eq("grant_id", grant_id, first);
                check_eq("rdata_idle_xfer", rdata, 0);
                if (scramble) begin
                    if (first == 0) begin r0_addr = $urandom; r0_wdata = $urandom; r0_size = 2'($urandom); end
                    else            begin r1_addr = $urandom; r1_wdata = $urandom; r1_size = 2'($urandom); end
                end
            end
            check_eq("ack_exclusive", {31'd0, r0_ack & r1_ack}, 0);
            if (r0_ack) begin
                check_eq("r0_ack_cycle", cyc, exp_cyc[0]);
                check_eq("r0_rdata", rdata, exp_val[0]);
                r0_req = 1'b0; done[0] = 1'b1;
            end
            if (r1_ack) begin
                check_eq("r1_ack_cycle", cyc, exp_cyc[1]);
                check_eq("r1_rdata", rdata, exp_val[1]);
                r1_req = 1'b0; done[1] = 1'b1;
            end
        end
        check_eq("all_acked", {30'd0, done[1], done[0]}, 2'b11);
        r0_req = 1'b0; r1_req = 1'b0;
    endtask

    initial begin
        logic [31:0] ra0, ra1;
        bit          e0, e1;
        for (int i = 0; i < 65536; i++) begin mem[i] = 8'd0; ref_mem[i] = 8'd0; end
        rst = 1'b1;
        r0_req = 0; r1_req = 0; r0_addr = 0; r1_addr = 0; r0_size = 0; r1_size = 0;
        r0_we = 0; r1_we = 0; r0_wdata = 0; r1_wdata = 0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_acks", {r1_ack, r0_ack}, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_grant", grant_id, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // tie after reset goes to port 0, and again on the following tie
        run_req(1, 1, 32'h30, 32'h34, 2, 2, 0, 0, 0, 0, 0);
        run_req(1, 1, 32'h30, 32'h34, 2, 2, 0, 0, 0, 0, 0);

        run_req(0, 1, 0, 32'h10, 0, 2, 0, 1, 0, 32'hDEADBEEF, 0);
        check_eq("m10", mem[16'h10], 8'hDE);
        check_eq("m11", mem[16'h11], 8'hAD);
        check_eq("m12", mem[16'h12], 8'hBE);
        check_eq("m13", mem[16'h13], 8'hEF);
        run_req(0, 1, 0, 32'h10, 0, 2, 0, 0, 0, 0, 0);

        run_req(1, 0, 32'h20, 0, 0, 0, 1, 0, 32'h12345678, 0, 0);
        check_eq("m20", mem[16'h20], 8'h78);
        run_req(0, 1, 0, 32'h1F, 0, 1, 0, 0, 0, 0, 0);

        run_req(1, 0, 32'hFFFE, 0, 2, 0, 1, 0, 32'hA1B2C3D4, 0, 0);
        check_eq("mFFFE", mem[16'hFFFE], 8'hA1);
        check_eq("mFFFF", mem[16'hFFFF], 8'hB2);
        check_eq("m0000", mem[16'h0000], 8'hC3);
        check_eq("m0001", mem[16'h0001], 8'hD4);

        run_req(0, 1, 0, 32'h50, 0, 2, 0, 1, 0, 32'hCAFEF00D, 1);
        run_req(0, 1, 0, 32'h50, 0, 2, 0, 0, 0, 0, 0);

        // reset while the second byte of a 32-bit write is on the bus
        @(negedge clk);
        r0_req = 1; r0_addr = 32'h40; r0_size = 2; r0_we = 1; r0_wdata = 32'h11223344;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_mid_we_before", mem_we, 1);
        check_eq("rst_mid_addr_before", mem_addr, 16'h41);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_we", mem_we, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_acks", {r1_ack, r0_ack}, 0);
        r0_req = 0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check_eq("rst_mid_m40", mem[16'h40], 8'h11);
        check_eq("rst_mid_m41", mem[16'h41], 8'h00);
        ref_mem[16'h40] = 8'h11;
        last_g = 1;
        run_req(1, 1, 32'h40, 32'h40, 2, 2, 0, 0, 0, 0, 0);

        for (int it = 0; it < 150; it++) begin
            e0  = 1'($urandom_range(0, 1));
            e1  = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
            ra0 = $urandom_range(0, 1) ? 32'($urandom_range(0, 63)) : (32'hFFFFFFF0 | 32'($urandom_range(0, 15)));
            ra1 = $urandom_range(0, 1) ? 32'($urandom_range(0, 63)) : (32'h1234FFF0 | 32'($urandom_range(0, 15)));
            run_req(e0, e1, ra0, ra1, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                    $urandom, $urandom, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/main_mem_arbiter.md
MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, giving the byte-RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports r0_req / r1_req  in  1  access request from port 0 (instruction fetch) / port 1 (data).
REQ-005 SHALL have ports rN_addr  in  32  byte address; only bits [ADDR_WIDTH-1:0] are used.
REQ-006 SHALL have ports rN_size  in  2  access size: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = treated as 32-bit.
REQ-007 SHALL have ports rN_we  in  1  access type: 1 = write, 0 = read.
REQ-008 SHALL have ports rN_wdata  in  32  write data.
REQ-009 SHALL have ports rN_ack  out  1  one-cycle completion pulse to the owning port.
REQ-010 SHALL have port rdata  out  32  read result; valid only while some rN_ack is high.
REQ-011 SHALL have port busy  out  1  high whenever the FSM is outside IDLE.
REQ-012 SHALL have port grant_id  out  1  port currently owning the access; held while busy.
REQ-013 SHALL have port mem_addr  out  ADDR_WIDTH  byte-RAM address.
REQ-014 SHALL have port mem_we  out  1  byte-RAM write enable.
REQ-015 SHALL have port mem_wdata  out  8  byte-RAM write data.
REQ-016 SHALL have port mem_rdata  in  8  byte-RAM read data, valid one cycle after mem_addr is presented.

Function
REQ-017 SHALL implement FSM states IDLE, XFER and ACK.
REQ-018 In IDLE, SHALL sample the rN_req lines at each rising edge; on any request, SHALL grant one port, latch its addr/size/we/wdata, set byte count N (1/2/4) and index k=0, and go to XFER.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, grant the port not granted last; a single request is granted immediately.
REQ-020 In XFER, byte k SHALL drive mem_addr = (base + k) mod 2^ADDR_WIDTH for one cycle, k = 0..N-1.
REQ-021 Ordering SHALL be big-endian: the byte at base is most significant.
REQ-022 Write byte k SHALL come from wdata bits [8*(N-1-k)+7 : 8*(N-1-k)], with mem_we high in each XFER cycle.
REQ-023 For reads, mem_we SHALL stay 0, and the byte returned for k SHALL be shifted into an accumulator in the following cycle.
REQ-024 After byte N-1 is driven, the FSM SHALL go to ACK.
REQ-025 In ACK, SHALL pulse the owner's rN_ack for one cycle; for reads, rdata = zero-extended accumulator (8-bit: {24'b0,b0}; 16-bit: {16'b0,b0,b1}); then return to IDLE.
REQ-026 Latency SHALL be: request sampled at edge T0; bytes on cycles 1..N; ack on cycle N+1; next grant no earlier than edge ending cycle N+2.
REQ-027 Requester fields changing after grant SHALL be ignored.
REQ-028 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-029 The non-granted port SHALL be kept waiting; its req is not dropped.
REQ-030 Outside XFER, mem_we SHALL be 0; both rN_ack SHALL never be high together.
REQ-031 rdata SHALL be 0 outside ACK and during write ACKs.

Reset
REQ-032 While rst is high, SHALL force IDLE immediately (asynchronously); all outputs 0; accumulator 0; last-grant = port 1 so port 0 wins the first tie.
REQ-033 Reset during XFER SHALL abort the access with no ack and drop mem_we in the same cycle; no latched request survives reset.

Verification
REQ-034 Write r1 addr=0x0010 size=2 wdata=0xDEADBEEF, then read same -> mem bytes 10..13 = DE,AD,BE,EF; write r1_ack on cycle 5; read rdata=0xDEADBEEF with r1_ack.
REQ-035 r0 and r1 request the same cycle after reset -> r0 granted first, r1 next; then simultaneous again -> r0 granted.
REQ-036 Write size=0 wdata=0x12345678 at 0x0020; read size=1 at 0x001F -> mem[0x20]=0x78; rdata=0x00000078 if mem[0x1F]=0.
REQ-037 32-bit write at 0xFFFE -> bytes land at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-038 Assert rst during the 2nd XFER byte of a 32-bit write -> mem_we=0 immediately, no ack, busy=0, only byte 0 written.
REQ-039 r1 changes addr and wdata one cycle after grant -> original latched values used.
